// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the forwarding selects, the memory-wait FSM states and the forwarding helper.
package pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_ME  = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } hz_state_e;

    // EX_ME result wins over ME_WB; r0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] me_rd,
        input logic             me_regwr,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_regwr
    );
        if (me_regwr && (me_rd != '0) && (me_rd == src))
            return FWD_ME;
        else if (wb_regwr && (wb_rd != '0) && (wb_rd == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stage enables/flushes, ALU forwarding,
// memory-wait timeout FSM and saturating stall/flush activity counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwr,
    input  logic             ex_mem2reg,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] me_rd,
    input  logic             me_regwr,
    input  logic             me_mem2reg,
    input  logic             me_memwr,
    input  logic             dmem_ready,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exme_en,
    output logic             mewb_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int            TW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

    hz_state_e     state_q;
    logic [TW-1:0] tcnt_q;
    logic          mem_err_q;

    logic memstall;
    logic loaduse;
    logic freeze;
    logic branch_flush;

    assign memstall = (me_mem2reg | me_memwr) & ~dmem_ready;
    assign loaduse  = ex_mem2reg & ex_regwr & (ex_rd != '0) &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign freeze       = (state_q == HALT) | memstall;
    assign branch_flush = ~freeze & branch_taken;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exme_en    = 1'b1;
        mewb_en    = 1'b1;
        if (freeze) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exme_en = 1'b0;
            mewb_en = 1'b0;
        end else if (branch_taken) begin
            // The load-use consumer in ID is squashed, so no bubble is needed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loaduse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign fwd_a = fwd_sel(ex_rs, me_rd, me_regwr, wb_rd, wb_regwr);
    assign fwd_b = fwd_sel(ex_rt, me_rd, me_regwr, wb_rd, wb_regwr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            tcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (memstall) begin
                        state_q <= WAIT;
                        tcnt_q  <= TW'(1);
                    end
                end
                WAIT: begin
                    if (!memstall) begin
                        state_q <= RUN;
                        tcnt_q  <= '0;
                    end else if (tcnt_q == TMAX) begin
                        state_q   <= HALT;
                        mem_err_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                HALT: begin
                    // Only reset leaves HALT; a late dmem_ready is ignored.
                    state_q   <= HALT;
                    mem_err_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                    tcnt_q  <= '0;
                end
            endcase
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_flush),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected results,
// a negedge monitor pops and compares them against the selected DUT instance.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, me_rd, wb_rd;
    logic       ex_regwr, ex_mem2reg, branch_taken;
    logic       me_regwr, me_mem2reg, me_memwr, dmem_ready, wb_regwr;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en, mewb_en;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_err;
    logic [15:0] stall_cycles, flush_events;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exme_en, s_mewb_en;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_mem_err;
    logic [3:0]  s_stall_cycles, s_flush_events;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwr(ex_regwr), .ex_mem2reg(ex_mem2reg), .branch_taken(branch_taken),
        .me_rd(me_rd), .me_regwr(me_regwr), .me_mem2reg(me_mem2reg), .me_memwr(me_memwr),
        .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exme_en(exme_en), .mewb_en(mewb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwr(ex_regwr), .ex_mem2reg(ex_mem2reg), .branch_taken(branch_taken),
        .me_rd(me_rd), .me_regwr(me_regwr), .me_mem2reg(me_mem2reg), .me_memwr(me_memwr),
        .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
        .idex_flush(s_idex_flush), .exme_en(s_exme_en), .mewb_en(s_mewb_en),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_err(s_mem_err),
        .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
    );

    // ctl bit order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en, mewb_en}
    localparam logic [6:0] NORM   = 7'b1101011;
    localparam logic [6:0] FREEZE = 7'b0000000;
    localparam logic [6:0] BR     = 7'b1111111;
    localparam logic [6:0] LU     = 7'b0001111;

    typedef struct {
        string       name;
        bit          sel;
        logic [6:0]  ctl;
        logic [3:0]  fwd;
        logic        err;
        logic [15:0] stall;
        logic [15:0] flush;
        bit          chk_cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string n, input bit sel, input logic [6:0] ctl,
                            input logic [3:0] fwd, input logic err,
                            input int st, input int fl, input bit chk);
        exp_t e;
        e.name = n; e.sel = sel; e.ctl = ctl; e.fwd = fwd; e.err = err;
        e.stall = 16'(st); e.flush = 16'(fl); e.chk_cnt = chk;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; me_rd = 0; wb_rd = 0;
        ex_regwr = 0; ex_mem2reg = 0; branch_taken = 0;
        me_regwr = 0; me_mem2reg = 0; me_memwr = 0; dmem_ready = 1; wb_regwr = 0;
    endtask

    task automatic reset_dut();
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    // Monitor: the controller presents a full set of outputs every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t        e;
                logic [43:0] act, req;
                e = q.pop_front();
                if (e.sel == 1'b0)
                    act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en, mewb_en,
                           fwd_a, fwd_b, mem_err,
                           e.chk_cnt ? stall_cycles : 16'h0, e.chk_cnt ? flush_events : 16'h0};
                else
                    act = {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exme_en,
                           s_mewb_en, s_fwd_a, s_fwd_b, s_mem_err,
                           e.chk_cnt ? {12'h0, s_stall_cycles} : 16'h0,
                           e.chk_cnt ? {12'h0, s_flush_events} : 16'h0};
                req = {e.ctl, e.fwd, e.err,
                       e.chk_cnt ? e.stall : 16'h0, e.chk_cnt ? e.flush : 16'h0};
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL %s actual ctl=%b fwd=%b err=%b stall=%0d flush=%0d required ctl=%b fwd=%b err=%b stall=%0d flush=%0d",
                             e.name, act[43:37], act[36:33], act[32], act[31:16], act[15:0],
                             req[43:37], req[36:33], req[32], req[31:16], req[15:0]);
                end else begin
                    $display("ok   %s ctl=%b fwd=%b err=%b stall=%0d flush=%0d",
                             e.name, act[43:37], act[36:33], act[32], act[31:16], act[15:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Reset state
        next_cycle();
        push_exp("in_reset", 0, NORM, 4'b0000, 0, 0, 0, 1);
        next_cycle();
        rst = 1'b0;
        push_exp("post_reset", 0, NORM, 4'b0000, 0, 0, 0, 1);

        // Load-use on rs: one bubble, then free
        next_cycle();
        ex_mem2reg = 1; ex_regwr = 1; ex_rd = 8; id_rs = 8;
        push_exp("loaduse_rs", 0, LU, 4'b0000, 0, 0, 0, 1);
        next_cycle();
        clear_inputs();
        push_exp("loaduse_clear", 0, NORM, 4'b0000, 0, 1, 0, 1);
        next_cycle();
        ex_mem2reg = 1; ex_regwr = 1; ex_rd = 8; id_rt = 8;
        push_exp("loaduse_rt", 0, LU, 4'b0000, 0, 1, 0, 1);
        next_cycle();
        ex_rd = 0; id_rt = 0; id_rs = 0;
        push_exp("loaduse_r0", 0, NORM, 4'b0000, 0, 2, 0, 1);

        // Branch with simultaneous load-use
        reset_dut();
        next_cycle();
        branch_taken = 1; ex_mem2reg = 1; ex_regwr = 1; ex_rd = 8; id_rs = 8;
        push_exp("branch_over_lu", 0, BR, 4'b0000, 0, 0, 0, 1);
        next_cycle();
        clear_inputs();
        push_exp("branch_counted", 0, NORM, 4'b0000, 0, 0, 1, 1);

        // Forwarding
        next_cycle();
        me_rd = 5; me_regwr = 1; wb_rd = 5; wb_regwr = 1; ex_rs = 5; ex_rt = 0;
        push_exp("fwd_me_prio", 0, NORM, 4'b1000, 0, 0, 1, 1);
        next_cycle();
        me_rd = 0;
        push_exp("fwd_me_r0", 0, NORM, 4'b0100, 0, 0, 1, 1);
        next_cycle();
        me_rd = 5; ex_rs = 0; ex_rt = 5;
        push_exp("fwd_b_me", 0, NORM, 4'b0010, 0, 0, 1, 1);
        next_cycle();
        me_regwr = 0; ex_rs = 5;
        push_exp("fwd_wb_both", 0, NORM, 4'b0101, 0, 0, 1, 1);
        next_cycle();
        wb_regwr = 0;
        push_exp("fwd_none", 0, NORM, 4'b0000, 0, 0, 1, 1);

        // Store with 3 cycles of memory wait; forwarding stays live
        reset_dut();
        next_cycle();
        me_memwr = 1; dmem_ready = 0; ex_rs = 9; wb_rd = 9; wb_regwr = 1;
        push_exp("memwait_c1", 0, FREEZE, 4'b0100, 0, 0, 0, 1);
        next_cycle();
        push_exp("memwait_c2", 0, FREEZE, 4'b0100, 0, 1, 0, 1);
        next_cycle();
        push_exp("memwait_c3", 0, FREEZE, 4'b0100, 0, 2, 0, 1);
        next_cycle();
        dmem_ready = 1;
        push_exp("memwait_done", 0, NORM, 4'b0100, 0, 3, 0, 1);
        next_cycle();
        clear_inputs();
        push_exp("memwait_after", 0, NORM, 4'b0000, 0, 3, 0, 1);

        // Timeout into HALT
        reset_dut();
        next_cycle();
        me_memwr = 1; dmem_ready = 0;
        for (int k = 2; k <= 17; k++) next_cycle();
        push_exp("timeout_c17", 0, FREEZE, 4'b0000, 0, 16, 0, 1);
        next_cycle();
        push_exp("halt_entered", 0, FREEZE, 4'b0000, 1, 17, 0, 1);
        next_cycle();
        dmem_ready = 1; me_memwr = 0;
        push_exp("halt_sticky", 0, FREEZE, 4'b0000, 1, 18, 0, 1);
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        push_exp("halt_rst", 0, NORM, 4'b0000, 0, 0, 0, 1);
        next_cycle();
        rst = 1'b0;
        push_exp("halt_released", 0, NORM, 4'b0000, 0, 0, 0, 1);

        // Saturation on the 4-bit counter instance (MEM_TIMEOUT=32)
        reset_dut();
        next_cycle();
        me_mem2reg = 1; dmem_ready = 0;
        for (int k = 2; k <= 16; k++) next_cycle();
        push_exp("sat_c16", 1, FREEZE, 4'b0000, 0, 15, 0, 1);
        for (int k = 17; k <= 20; k++) next_cycle();
        push_exp("sat_c20", 1, FREEZE, 4'b0000, 0, 15, 0, 1);
        next_cycle();
        dmem_ready = 1;
        push_exp("sat_release", 1, NORM, 4'b0000, 0, 15, 0, 1);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual pending=%0d required pending=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
